// File: rtl/ber_checker.sv
// ber_checker: self-synchronising PRBS-7 bit-error-ratio receiver.
// Optional err_mask output is enabled by defining BER_ERR_MASK_EN.
module ber_checker #(
    parameter int CNT_W      = 32,
    parameter int SYNC_BYTES = 4,
    parameter int WIN_BYTES  = 64,
    parameter int LOSS_THR   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
`ifdef BER_ERR_MASK_EN
    ,
    output logic [7:0]       err_mask
`endif
);

    localparam int MW = $clog2(SYNC_BYTES + 1);
    localparam int WW = $clog2(WIN_BYTES + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    // Eight serial steps of x^7+x^6+1; first output bit lands in [7].
    // The last seven outputs are also the advanced register contents.
    function automatic logic [7:0] prbs_exp(input logic [6:0] seed);
        logic [6:0] s;
        logic       nb;
        logic [7:0] r;
        s = seed;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            nb       = s[6] ^ s[5];
            s        = {s[5:0], nb};
            r[7 - i] = nb;
        end
        return r;
    endfunction

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [3:0]       b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W - 3){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_q, win_d;
    logic [EW-1:0]    errb_q, errb_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             err_flag_q, err_flag_d;
`ifdef BER_ERR_MASK_EN
    logic [7:0]       err_mask_q, err_mask_d;
`endif

    logic [7:0]    exp_byte;
    logic [7:0]    mask;
    logic [3:0]    nerr;
    logic [WW-1:0] win_nx;
    logic [EW-1:0] errb_nx;

    // Hunt/lock state machine, error accounting and window monitor.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        match_d    = match_q;
        win_d      = win_q;
        errb_d     = errb_q;
        err_cnt_d  = err_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        err_flag_d = 1'b0;
`ifdef BER_ERR_MASK_EN
        err_mask_d = 8'h00;
`endif
        exp_byte = prbs_exp(lfsr_q);
        mask     = din ^ exp_byte;
        nerr     = popcnt8(mask);
        win_nx   = win_q + WW'(1);
        errb_nx  = errb_q + EW'(nerr != 4'd0);

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Reseeding from din equals the 8-step advance on a match.
                    lfsr_d = din[6:0];
                    if (mask == 8'h00 && lfsr_q != 7'h00) begin
                        if (match_q == MW'(SYNC_BYTES - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            errb_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    lfsr_d     = exp_byte[6:0];
                    err_cnt_d  = sat_add(err_cnt_q, nerr);
                    bit_cnt_d  = sat_add(bit_cnt_q, 4'd8);
                    err_flag_d = (nerr != 4'd0);
`ifdef BER_ERR_MASK_EN
                    err_mask_d = mask;
`endif
                    if (errb_nx == EW'(LOSS_THR)) begin
                        state_d = HUNT;
                        match_d = '0;
                        lfsr_d  = din[6:0];
                        win_d   = '0;
                        errb_d  = '0;
                    end else if (win_nx == WW'(WIN_BYTES)) begin
                        win_d  = '0;
                        errb_d = '0;
                    end else begin
                        win_d  = win_nx;
                        errb_d = errb_nx;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d  = '0;
            bit_cnt_d  = '0;
            err_flag_d = 1'b0;
`ifdef BER_ERR_MASK_EN
            err_mask_d = 8'h00;
`endif
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            lfsr_q     <= 7'h00;
            match_q    <= '0;
            win_q      <= '0;
            errb_q     <= '0;
            err_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            match_q    <= match_d;
            win_q      <= win_d;
            errb_q     <= errb_d;
            err_cnt_q  <= err_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

`ifdef BER_ERR_MASK_EN
    // Per-byte error mask, registered alongside err_flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mask_q <= 8'h00;
        end else begin
            err_mask_q <= err_mask_d;
        end
    end

    assign err_mask = err_mask_q;
`endif

    assign locked   = (state_q == LOCKED);
    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Receive-side companion of the byte-wide error-injection path in the bit-error-ratio tester.
- Takes the 8-bit byte stream after the channel or error injector and self-synchronises a local PRBS-7 generator to it.
- Once locked, compares every received byte with the expected byte and accumulates bit-error and bit counts for BER computation.
- Detects loss of sync and re-hunts automatically.

Parameters:
- CNT_W, 32, width of err_cnt and bit_cnt; both saturate at all-ones.
- SYNC_BYTES, 4, consecutive error-free predicted bytes required to declare lock.
- WIN_BYTES, 64, length in valid bytes of the loss-of-lock monitoring window.
- LOSS_THR, 8, errored bytes within one window that force loss of lock.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  received byte; serial order MSB first (din[7] oldest bit, din[0] newest).
- din_valid  input  1  din is valid this cycle; all state advances only when high.
- clr_cnt  input  1  synchronous clear of err_cnt, bit_cnt and err_flag; lock state is unaffected.
- locked  output  1  high while in LOCKED.
- err_flag  output  1  one-cycle pulse: the previous valid byte (in LOCKED) had at least one bit error.
- err_cnt  output  CNT_W  accumulated bit errors while locked.
- bit_cnt  output  CNT_W  accumulated bits compared while locked (+8 per byte).

Behaviour:
- Reset (async, rst_n=0): state=HUNT, lfsr=0, match_cnt=0, window counters=0; locked=0, err_flag=0, err_cnt=0, bit_cnt=0.
- PRBS-7 polynomial x^7+x^6+1:
  - per serial step: new = s[6]^s[5]; s <= {s[5:0], new}; the output bit is new.
  - Expected byte = 8 successive output bits, first bit in [7].
  - lfsr advances 8 steps per valid byte, computed combinationally in one cycle.
- HUNT, on din_valid:
  - compare din with the expected byte from the current lfsr.
  - Match and lfsr!=0: match_cnt++. Otherwise: match_cnt=0.
  - Always reseed lfsr <= din[6:0]. This equals the 8-step advance when the byte matches.
  - An all-zero seed never counts as a match.
  - When match_cnt would reach SYNC_BYTES: go to LOCKED next cycle, locked=1, window counters cleared.
  - Counters do not change in HUNT. err_flag stays 0.
- LOCKED, on din_valid:
  - lfsr advances 8 steps from its own state; it is never reseeded from din.
  - mask = din ^ expected; e = popcount(mask), 0..8.
  - err_cnt += e and bit_cnt += 8, each saturating at 2^CNT_W-1.
  - err_flag = (e!=0) on the next cycle only.
  - win_cnt++ each byte. errb_cnt++ when e!=0.
  - When errb_cnt reaches LOSS_THR: go to HUNT next cycle, locked=0, match_cnt=0, lfsr reseeded from that byte's din[6:0]. The accumulated counts keep their values.
  - When win_cnt reaches WIN_BYTES without loss: both window counters restart at 0.
- din_valid=0: no state change; err_flag=0.
- clr_cnt and valid byte in the same cycle: clear wins; that byte's contribution is discarded and err_flag=0.
- Latency: outputs are registered, one cycle after the din_valid edge.
- Reset mid-stream: immediate return to HUNT with all outputs at reset values.

Optional Feature:
- Macro: BER_ERR_MASK_EN.
- Defined:
  - adds output err_mask[7:0], registered alongside err_flag.
  - Holds mask of the last valid byte compared in LOCKED; otherwise 0.
  - Reset value 8'h00; cleared by clr_cnt.
- Undefined: port and register absent. All other behaviour is identical.

Test Plan:
- After reset, din=8'h7F then 8'h02 valid -> second byte counts as match (lfsr=7'h7F predicts 8'h02). Continue a clean PRBS-7 stream: locked rises on the cycle after the 5th valid byte (seed byte plus SYNC_BYTES matches). err_cnt=0.
- Locked, clean stream for 100 bytes -> bit_cnt=800, err_cnt=0, err_flag never high.
- Locked, flip bits 3 and 0 of one byte -> err_cnt=2, err_flag pulses once. With BER_ERR_MASK_EN, err_mask=8'h09.
- Locked, corrupt 8 bytes within a 64-byte window (1 bit each) -> locked falls the cycle after the 8th, err_cnt=8. A clean stream then relocks with counts retained.
- Constant din=8'h00 stream -> locked never asserts.
- clr_cnt asserted with an errored valid byte -> err_cnt=0, bit_cnt=0, err_flag=0 next cycle. Async rst_n pulse while locked -> locked=0 immediately.
